// File: rtl/fnn_pkg.sv
// Shared types and saturating arithmetic helpers for the fully-connected neuron blocks.
// Helpers work on a wide signed container; callers size-cast operands in and results out.
package fnn_pkg;

  localparam int MAXW = 72;

  typedef enum logic {
    ACT_LINEAR = 1'b0,
    ACT_RELU   = 1'b1
  } act_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    BIAS,
    ACT,
    OUT
  } neuron_state_t;

  // Clamp x into the signed range of to_width bits; sat reports whether clamping happened.
  function automatic logic signed [MAXW-1:0] sat_trunc(
    input  logic signed [MAXW-1:0] x,
    input  int                     to_width,
    output logic                   sat
  );
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi  = (MAXW'(1) <<< (to_width - 1)) - MAXW'(1);
    lo  = ~hi;
    sat = 1'b0;
    if (x > hi) begin
      sat_trunc = hi;
      sat       = 1'b1;
    end else if (x < lo) begin
      sat_trunc = lo;
      sat       = 1'b1;
    end else begin
      sat_trunc = x;
    end
  endfunction

  // Operands never exceed ~68 bits, so the raw sum cannot wrap inside MAXW.
  function automatic logic signed [MAXW-1:0] sat_add(
    input  logic signed [MAXW-1:0] a,
    input  logic signed [MAXW-1:0] b,
    input  int                     width,
    output logic                   sat
  );
    sat_add = sat_trunc(a + b, width, sat);
  endfunction

endpackage

// File: rtl/neuron_wmem_banked.sv
// Lane-banked weight RAM: one bank per lane, weight k lands in bank k%NUM_LANES, row k/NUM_LANES.
// Writes advance a wrapping pointer on config match; reads are registered (1 cycle).
module neuron_wmem_banked #(
  parameter  int LAYER_NO   = 1,
  parameter  int NEURON_NO  = 0,
  parameter  int NUM_WEIGHT = 784,
  parameter  int NUM_LANES  = 4,
  parameter  int DATA_W     = 16,
  localparam int ROWS       = NUM_WEIGHT / NUM_LANES,
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_allow,
  input  logic                        weight_valid,
  input  logic [31:0]                 weight_value,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  output logic                        cfg_hit,
  input  logic                        rd_en,
  input  logic [RW-1:0]               rd_row,
  output logic [NUM_LANES*DATA_W-1:0] rd_data
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [RW-1:0] wrow;
  logic [LW-1:0] wlane;
  logic          wr_en;
  logic          unused_bits;

  assign cfg_hit     = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign wr_en       = wr_allow && weight_valid && cfg_hit;
  assign unused_bits = ^weight_value;

  // Row/lane pair walks the same order as a flat index, without a divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrow  <= '0;
      wlane <= '0;
    end else if (wr_en) begin
      if (wlane == LW'(NUM_LANES - 1)) begin
        wlane <= '0;
        wrow  <= (wrow == RW'(ROWS - 1)) ? '0 : wrow + RW'(1);
      end else begin
        wlane <= wlane + LW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_bank
    logic [DATA_W-1:0] bank [ROWS];
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
      if (wr_en && (wlane == LW'(i))) bank[wrow] <= weight_value[DATA_W-1:0];
      if (rd_en) q <= bank[rd_row];
    end

    assign rd_data[i*DATA_W +: DATA_W] = q;
  end

endmodule

// File: rtl/neuron_mac_gen.sv
// Multi-lane signed MAC neuron: saturating Q-format accumulate, runtime bias and linear/ReLU output.
// Pipeline per beat: RAM read + input reg, lane products, tree sum, accumulate; result 5 edges after last beat.
module neuron_mac_gen #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 784,
  parameter int NUM_LANES  = 4,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        weight_valid,
  input  logic [31:0]                 weight_value,
  input  logic                        bias_valid,
  input  logic [31:0]                 bias_value,
  input  logic [31:0]                 config_layer_num,
  input  logic [31:0]                 config_neuron_num,
  input  logic                        act_mode,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat_flag,
  output logic                        busy
);
  import fnn_pkg::*;

  localparam int ROWS   = NUM_WEIGHT / NUM_LANES;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);
  localparam int ACC_W  = 2 * DATA_W;

  neuron_state_t state, state_nxt;
  act_mode_t     act_q;
  logic [1:0]    drain_cnt;
  logic [RW-1:0] beat_cnt;
  logic          fire, last_beat, cfg_hit;
  logic          v0, v1, v2;
  logic [DATA_W-1:0]           bias_q;
  logic [NUM_LANES*DATA_W-1:0] x_q, w_q;
  logic signed [PROD_W-1:0]    prod_c [NUM_LANES];
  logic signed [PROD_W-1:0]    prod_q [NUM_LANES];
  logic signed [SUM_W-1:0]     sum_c, sum_q;
  logic signed [ACC_W-1:0]     acc;
  logic signed [MAXW-1:0]      tree_w, acc_add_w, bias_w, y_shift, y_w;
  logic                        tree_sat, acc_sat, bias_sat, y_sat;
  logic                        unused_bits;

  assign in_ready    = (state == IDLE) || (state == ACCUM);
  assign fire        = in_valid && in_ready;
  assign last_beat   = (beat_cnt == RW'(ROWS - 1));
  assign busy        = (state != IDLE);
  assign out_valid   = (state == OUT);
  assign unused_bits = ^{bias_value, acc_add_w, bias_w, y_w};

  neuron_wmem_banked #(
    .LAYER_NO  (LAYER_NO),
    .NEURON_NO (NEURON_NO),
    .NUM_WEIGHT(NUM_WEIGHT),
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W)
  ) u_wmem (
    .clk              (clk),
    .rst              (rst),
    .wr_allow         (state == IDLE),
    .weight_valid     (weight_valid),
    .weight_value     (weight_value),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .cfg_hit          (cfg_hit),
    .rd_en            (fire),
    .rd_row           (beat_cnt),
    .rd_data          (w_q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (fire) state_nxt = last_beat ? DRAIN : ACCUM;
      DRAIN:       if (drain_cnt == 2'd2) state_nxt = BIAS;
      BIAS:        state_nxt = ACT;
      ACT:         state_nxt = OUT;
      OUT:         if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      prod_c[i] = PROD_W'($signed(x_q[i*DATA_W +: DATA_W])) * PROD_W'($signed(w_q[i*DATA_W +: DATA_W]));
      sum_c     = sum_c + SUM_W'(prod_q[i]);
    end
  end

  always_comb begin
    tree_w    = sat_trunc(MAXW'(sum_q), ACC_W, tree_sat);
    acc_add_w = sat_add(MAXW'(acc), tree_w, ACC_W, acc_sat);
    bias_w    = sat_add(MAXW'(acc), MAXW'($signed(bias_q)) <<< FRAC_W, ACC_W, bias_sat);
    y_shift   = MAXW'(acc) >>> FRAC_W;
    y_w       = sat_trunc(y_shift, DATA_W, y_sat);
  end

  // The accumulate (v2) lands while still in DRAIN, so it never collides with BIAS/ACT updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      act_q     <= ACT_LINEAR;
      drain_cnt <= '0;
      beat_cnt  <= '0;
      bias_q    <= '0;
      x_q       <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= '0;
      sum_q     <= '0;
      acc       <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      v0        <= fire;
      v1        <= v0;
      v2        <= v1;
      prod_q    <= prod_c;
      sum_q     <= sum_c;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (fire) begin
        x_q      <= in_data;
        beat_cnt <= last_beat ? '0 : beat_cnt + RW'(1);
        if (state == IDLE) begin
          act_q    <= act_mode_t'(act_mode);
          sat_flag <= 1'b0;
        end
      end
      if ((state == IDLE) && bias_valid && cfg_hit) bias_q <= bias_value[DATA_W-1:0];
      if (v2) begin
        acc      <= ACC_W'(acc_add_w);
        sat_flag <= sat_flag | tree_sat | acc_sat;
      end
      if (state == BIAS) begin
        acc      <= ACC_W'(bias_w);
        sat_flag <= sat_flag | bias_sat;
      end
      if (state == ACT) begin
        out_data <= ((act_q == ACT_RELU) && y_w[MAXW-1]) ? '0 : y_w[DATA_W-1:0];
        sat_flag <= sat_flag | y_sat;
      end
      if ((state == OUT) && out_ready) acc <= '0;
    end
  end

endmodule

// File: tb/tb_neuron_mac_gen.sv
// Directed bench for neuron_mac_gen (4 weights, 2 lanes, Q8.8) with an expected-result queue.
module tb_neuron_mac_gen;

  localparam int NW = 4;
  localparam int NL = 2;
  localparam int DW = 16;
  localparam int FW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NL*DW-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           weight_valid = 1'b0;
  logic [31:0]    weight_value = '0;
  logic           bias_valid = 1'b0;
  logic [31:0]    bias_value = '0;
  logic [31:0]    config_layer_num = '0;
  logic [31:0]    config_neuron_num = '0;
  logic           act_mode = 1'b0;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           sat_flag;
  logic           busy;

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q [$];

  neuron_mac_gen #(
    .LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .NUM_LANES(NL), .DATA_W(DW), .FRAC_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .act_mode(act_mode), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_w(input logic [15:0] v, input int layer, input int neuron);
    config_layer_num  = layer;
    config_neuron_num = neuron;
    weight_value      = {16'hA5A5, v};
    weight_valid      = 1'b1;
    @(negedge clk);
    weight_valid      = 1'b0;
  endtask

  task automatic wr_b(input logic [15:0] v);
    config_layer_num  = 1;
    config_neuron_num = 0;
    bias_value        = {16'h5A5A, v};
    bias_valid        = 1'b1;
    @(negedge clk);
    bias_valid        = 1'b0;
  endtask

  task automatic wr_w4(input logic [15:0] v);
    for (int i = 0; i < NW; i++) wr_w(v, 1, 0);
  endtask

  // Two beats (b0 then b1); act_mode flips on the second beat and must be ignored.
  task automatic run(input logic [31:0] b0, input logic [31:0] b1, input logic mode,
                     input logic [15:0] exp_d, input logic exp_s, input int hold, input string tag);
    logic [16:0] e;
    int n;
    exp_q.push_back({exp_s, exp_d});
    check({tag, "_rdy_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = b0;
    act_mode = mode;
    @(negedge clk);
    check({tag, "_sat_clr"}, sat_flag, 0);
    in_data  = b1;
    act_mode = ~mode;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, "_rdy_drain"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 5);
    e = exp_q.pop_front();
    check({tag, "_data"}, out_data, {16'h0, e[15:0]});
    check({tag, "_sat"}, sat_flag, {31'h0, e[16]});
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, out_valid, 1);
      check({tag, "_hold_data"}, out_data, {16'h0, e[15:0]});
      check({tag, "_hold_rdy"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_vld"}, out_valid, 0);
    check({tag, "_post_rdy"}, in_ready, 1);
    check({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // 4 x (1.0 * 1.0) + 0.5
    wr_w4(16'h0100);
    wr_b(16'h0080);
    run({16'h0100, 16'h0100}, {16'h0100, 16'h0100}, 1'b1, 16'h0480, 1'b0, 0, "unit");

    // 4 x (-1.0 * 2.0) = -8.0
    wr_w4(16'hFF00);
    wr_b(16'h0000);
    run({16'h0200, 16'h0200}, {16'h0200, 16'h0200}, 1'b1, 16'h0000, 1'b0, 0, "neg_relu");
    run({16'h0200, 16'h0200}, {16'h0200, 16'h0200}, 1'b0, 16'hF800, 1'b0, 0, "neg_lin");

    // Max positive products saturate the accumulator on the second beat
    wr_w4(16'h7FFF);
    run({16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF}, 1'b0, 16'h7FFF, 1'b1, 0, "sat");
    run(32'h0, 32'h0, 1'b0, 16'h0000, 1'b0, 10, "clean_hold");

    // Non-matching writes are dropped; six matching writes wrap into slots 0 and 1
    wr_w(16'h7FFF, 1, 1);
    wr_w(16'h7FFF, 2, 0);
    wr_w(16'h0100, 1, 0);
    wr_w(16'h0100, 1, 0);
    wr_w(16'h0200, 1, 0);
    wr_w(16'h0300, 1, 0);
    wr_w(16'h0400, 1, 0);
    wr_w(16'h0500, 1, 0);
    wr_b(16'h0100);
    // 4*1 + 5*2 + 2*3 + 3*4 + 1 = 33.0
    run({16'h0200, 16'h0100}, {16'h0400, 16'h0300}, 1'b0, 16'h2100, 1'b0, 0, "wrap");

    // Reset in mid-accumulation; weights survive, bias returns to zero
    in_valid = 1'b1;
    in_data  = {16'h0200, 16'h0100};
    act_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_sat", sat_flag, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run({16'h0200, 16'h0100}, {16'h0400, 16'h0300}, 1'b0, 16'h2000, 1'b0, 0, "after_rst");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
